// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_tx_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned IDX_W      = $clog2(DATA_W);
  localparam logic        IDLE_LEVEL = 1'b1;

  // PARITY keeps its encoding even when the parity option is not built.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, restarts from 0 on clear.
// bit_end is high in the last cycle of a bit; bit_end_next_c predicts it one cycle ahead.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next_c
);

  localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap at LAST, forced to zero on clear.
  always_comb begin
    cnt_d = '0;
    if (!clear && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bit_end_next_c = (cnt_d == LAST);

  // Count register and registered end-of-bit flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_end <= bit_end_next_c;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and serialises them as UART frames
// (start, 8 data bits LSB first, optional even parity, STOP_BITS stop bits).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [IDX_W-1:0]  bit_idx_d;
  logic              stop_idx_q;
  logic              stop_idx_d;
  logic              bit_end;
  logic              bit_end_next_c;
  logic              baud_clear_c;
  logic              tx_d;
  logic              rd_d;
  logic              busy_d;
  logic              done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q;
  logic              parity_d;
`endif

  assign baud_clear_c = (state_d != state_q);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk           (clk),
    .reset         (reset),
    .clear         (baud_clear_c),
    .bit_end       (bit_end),
    .bit_end_next_c(bit_end_next_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; frame-start decisions only in IDLE and the last stop cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD:  state_d = START;
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_idx_q == IDX_W'(DATA_W - 1))) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end && (stop_idx_q == STOP_LAST)) begin
          if (tx_enable && !fifo_empty) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values, derived from the upcoming state.
  always_comb begin
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    tx_d       = IDLE_LEVEL;
    rd_d       = (state_d == FETCH);
    busy_d     = (state_d != IDLE);
    done_d     = 1'b0;

    if (state_q == LOAD) begin
      shift_d = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d = ^fifo_data;
`endif
    end
    if ((state_q == DATA) && bit_end) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = bit_idx_q + IDX_W'(1);
    end
    if ((state_q == STOP) && bit_end) begin
      stop_idx_d = stop_idx_q + 1'b1;
    end
    if (state_d != state_q) begin
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
    end

    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase

    done_d = (state_d == STOP) && (stop_idx_d == STOP_LAST) && bit_end_next_c;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
      tx           <= IDLE_LEVEL;
      fifo_read_en <= 1'b0;
      busy         <= 1'b0;
      byte_done    <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
      tx           <= tx_d;
      fifo_read_en <= rd_d;
      busy         <= busy_d;
      byte_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance with 1 stop bit fed by a
// small FIFO model, one with 2 stop bits fed by a fixed byte.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_enable_a;
  logic       tx_enable_b;
  logic       fifo_empty_a;
  logic       fifo_empty_b;
  logic [7:0] fifo_data_a = 8'h00;
  logic [7:0] fifo_data_b;
  logic       rd_a;
  logic       rd_b;
  logic       tx_a;
  logic       tx_b;
  logic       busy_a;
  logic       busy_b;
  logic       done_a;
  logic       done_b;

  logic [7:0] mem [0:15];
  int         wr_cnt   = 0;
  int         rd_ptr   = 0;
  int         pops_a   = 0;
  int         pops_b   = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  assign fifo_empty_a = (rd_ptr == wr_cnt);
  assign fifo_data_b  = 8'h3C;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .tx_enable   (tx_enable_a),
    .fifo_empty  (fifo_empty_a),
    .fifo_data   (fifo_data_a),
    .fifo_read_en(rd_a),
    .tx          (tx_a),
    .busy        (busy_a),
    .byte_done   (done_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .tx_enable   (tx_enable_b),
    .fifo_empty  (fifo_empty_b),
    .fifo_data   (fifo_data_b),
    .fifo_read_en(rd_b),
    .tx          (tx_b),
    .busy        (busy_b),
    .byte_done   (done_b)
  );

  // FIFO model: read data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (rd_a) begin
      fifo_data_a <= mem[rd_ptr[3:0]];
      rd_ptr      <= rd_ptr + 1;
      pops_a      <= pops_a + 1;
    end
    if (rd_b) begin
      pops_b <= pops_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_cnt[3:0]] = d;
    wr_cnt = wr_cnt + 1;
  endtask

  // Expected line level for frame bit b: start, data LSB first, parity, stops.
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[3'(b - 1)];
    if ((PAR_BITS == 1) && (b == 9)) return ^d;
    return 1'b1;
  endfunction

  // The two pre-frame cycles: FETCH (pop strobe) then LOAD, line high, busy.
  task automatic fetch_load(input bit sel);
    @(negedge clk);
    check("fetch_rd",   32'(sel ? rd_b   : rd_a),   32'd1);
    check("fetch_tx",   32'(sel ? tx_b   : tx_a),   32'd1);
    check("fetch_busy", 32'(sel ? busy_b : busy_a), 32'd1);
    @(negedge clk);
    check("load_rd",    32'(sel ? rd_b   : rd_a),   32'd0);
    check("load_tx",    32'(sel ? tx_b   : tx_a),   32'd1);
    check("load_busy",  32'(sel ? busy_b : busy_a), 32'd1);
  endtask

  // Every cycle of one frame, starting at the first START cycle.
  task automatic run_frame(input bit sel, input logic [7:0] data, input int drop_at);
    int nbits;
    nbits = 9 + PAR_BITS + (sel ? 2 : 1);
    for (int i = 0; i < nbits * CPB; i++) begin
      @(negedge clk);
      check($sformatf("tx_%0h_cyc%0d", data, i), 32'(sel ? tx_b : tx_a),
            32'(frame_bit(data, i / CPB)));
      check($sformatf("done_%0h_cyc%0d", data, i), 32'(sel ? done_b : done_a),
            32'(i == nbits * CPB - 1));
      check("busy_frame", 32'(sel ? busy_b : busy_a), 32'd1);
      check("rd_frame",   32'(sel ? rd_b   : rd_a),   32'd0);
      if (i == drop_at) tx_enable_a = 1'b0;
    end
  endtask

  initial begin
    reset        = 1'b0;
    tx_enable_a  = 1'b1;
    tx_enable_b  = 1'b1;
    fifo_empty_b = 1'b0;
    push(8'hA5);

    // Held in reset with data waiting and enable high: nothing moves.
    repeat (4) begin
      @(negedge clk);
      check("rst_tx_a",   32'(tx_a),   32'd1);
      check("rst_rd_a",   32'(rd_a),   32'd0);
      check("rst_busy_a", 32'(busy_a), 32'd0);
      check("rst_done_a", 32'(done_a), 32'd0);
      check("rst_tx_b",   32'(tx_b),   32'd1);
      check("rst_rd_b",   32'(rd_b),   32'd0);
    end
    tx_enable_a = 1'b0;
    tx_enable_b = 1'b0;
    reset       = 1'b1;

    // Enable low with a non-empty FIFO: no pop.
    repeat (6) begin
      @(negedge clk);
      check("gate_tx",   32'(tx_a),   32'd1);
      check("gate_rd",   32'(rd_a),   32'd0);
      check("gate_busy", 32'(busy_a), 32'd0);
    end
    check("gate_pops", 32'(pops_a), 32'd0);

    // Single byte 0xA5.
    tx_enable_a = 1'b1;
    fetch_load(1'b0);
    run_frame(1'b0, 8'hA5, -1);
    @(negedge clk);
    check("single_idle_busy", 32'(busy_a), 32'd0);
    check("single_idle_tx",   32'(tx_a),   32'd1);
    check("single_idle_rd",   32'(rd_a),   32'd0);
    check("single_pops",      32'(pops_a), 32'd1);

    // Back-to-back 0x00 then 0xFF: two-cycle high gap, busy held.
    push(8'h00);
    push(8'hFF);
    fetch_load(1'b0);
    run_frame(1'b0, 8'h00, -1);
    fetch_load(1'b0);
    run_frame(1'b0, 8'hFF, -1);
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy_a), 32'd0);
    check("b2b_pops",      32'(pops_a), 32'd3);

    // Parity-sensitive pair 0x07 (odd count) and 0x03 (even count).
    push(8'h07);
    push(8'h03);
    fetch_load(1'b0);
    run_frame(1'b0, 8'h07, -1);
    fetch_load(1'b0);
    run_frame(1'b0, 8'h03, -1);
    @(negedge clk);
    check("par_idle_busy", 32'(busy_a), 32'd0);
    check("par_pops",      32'(pops_a), 32'd5);

    // Enable dropped mid-frame: frame completes, second byte stays queued.
    push(8'h5A);
    push(8'h81);
    fetch_load(1'b0);
    run_frame(1'b0, 8'h5A, 10);
    repeat (8) begin
      @(negedge clk);
      check("drop_rd",   32'(rd_a),   32'd0);
      check("drop_tx",   32'(tx_a),   32'd1);
      check("drop_busy", 32'(busy_a), 32'd0);
    end
    check("drop_pops", 32'(pops_a), 32'd6);

    // Reset during a low data bit of 0x81: line returns high at once.
    tx_enable_a = 1'b1;
    fetch_load(1'b0);
    repeat (9) @(negedge clk);
    check("pre_rst_tx", 32'(tx_a), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx",   32'(tx_a),   32'd1);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_rd",   32'(rd_a),   32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    tx_enable_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_tx",   32'(tx_a),   32'd1);
      check("post_rst_busy", 32'(busy_a), 32'd0);
    end
    check("post_rst_pops", 32'(pops_a), 32'd7);

    // Two stop bits, byte 0x3C.
    tx_enable_b = 1'b1;
    fetch_load(1'b1);
    fifo_empty_b = 1'b1;
    run_frame(1'b1, 8'h3C, -1);
    @(negedge clk);
    check("stop2_idle_busy", 32'(busy_b), 32'd0);
    check("stop2_idle_tx",   32'(tx_b),   32'd1);
    check("stop2_pops",      32'(pops_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
